// File: rtl/multicycle_useq_if.sv
// Control/status bundle between the multicycle microsequencer and the datapath.
// master = sequencer side, slave = datapath / instruction-register side.
interface multicycle_useq_if #(
  parameter int WORD_SIZE = 16
);
  logic [WORD_SIZE-1:0] inst;
  logic                 mem_ready;

  logic                 alu_src_a;
  logic                 i_or_d;
  logic                 ir_write;
  logic                 pc_write;
  logic                 pc_write_cond;
  logic [2:0]           alu_src_b;
  logic [1:0]           pc_source;
  logic [1:0]           reg_dest;
  logic [1:0]           reg_write_src;
  logic [1:0]           branch_property;
  logic [1:0]           alu_op;
  logic                 reg_write;
  logic                 mem_read;
  logic                 mem_write;
  logic                 output_port_write;
  logic                 is_lhi;

  logic                 halted;
  logic                 illegal_inst;
  logic                 bus_error;
  logic [WORD_SIZE-1:0] num_inst;
  logic [4:0]           state;

  modport master (
    input  inst, mem_ready,
    output alu_src_a, i_or_d, ir_write, pc_write, pc_write_cond, alu_src_b,
           pc_source, reg_dest, reg_write_src, branch_property, alu_op,
           reg_write, mem_read, mem_write, output_port_write, is_lhi,
           halted, illegal_inst, bus_error, num_inst, state
  );

  modport slave (
    output inst, mem_ready,
    input  alu_src_a, i_or_d, ir_write, pc_write, pc_write_cond, alu_src_b,
           pc_source, reg_dest, reg_write_src, branch_property, alu_op,
           reg_write, mem_read, mem_write, output_port_write, is_lhi,
           halted, illegal_inst, bus_error, num_inst, state
  );
endinterface

// File: rtl/multicycle_useq.sv
// Registered microsequencer for the multicycle 16-bit CPU: decodes the IR into
// datapath controls, handles memory wait states with a timeout, counts retirements.
//
// state  code | meaning
// FETCH     0 | read instruction, PC+1; waits on mem_ready
// DECODE    1 | branch target precompute, dispatch
// R_EX/R_WB 2/3 | R-type execute / write rd
// ADI/ORI/LHI 4/5/6 | immediate execute;  WB_RT 7 | write rt
// ADDR 8 | address calc;  MEM_RD 9 / LD_WB 10 | load;  MEM_WR 11 | store
// BRANCH 12 | conditional PC;  JMP/JPR/JAL/JRL 13-16 | jumps;  WWD 17 | output port
// HALT  18 | terminal, left only by reset
module multicycle_useq #(
  parameter int WORD_SIZE  = 16,
  parameter int WAIT_LIMIT = 15,
  parameter int WAIT_W     = 8
) (
  input logic              clk,
  input logic              reset,
  multicycle_useq_if.master bus
);
  localparam logic [3:0] OP_BNE = 4'd0,  OP_BEQ = 4'd1,  OP_BGZ = 4'd2,  OP_BLZ = 4'd3;
  localparam logic [3:0] OP_ADI = 4'd4,  OP_ORI = 4'd5,  OP_LHI = 4'd6,  OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8,  OP_JMP = 4'd9,  OP_JAL = 4'd10, OP_ALU = 4'd15;
  localparam logic [5:0] FN_ADD = 6'd0,  FN_SUB = 6'd1,  FN_AND = 6'd2,  FN_ORR = 6'd3;
  localparam logic [5:0] FN_NOT = 6'd4,  FN_TCP = 6'd5,  FN_SHL = 6'd6,  FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25, FN_JRL = 6'd26, FN_WWD = 6'd28, FN_HLT = 6'd29;

  typedef enum logic [4:0] {
    ST_FETCH  = 5'd0,  ST_DECODE = 5'd1,  ST_R_EX   = 5'd2,  ST_R_WB  = 5'd3,
    ST_ADI    = 5'd4,  ST_ORI    = 5'd5,  ST_LHI    = 5'd6,  ST_WB_RT = 5'd7,
    ST_ADDR   = 5'd8,  ST_MEM_RD = 5'd9,  ST_LD_WB  = 5'd10, ST_MEM_WR = 5'd11,
    ST_BRANCH = 5'd12, ST_JMP    = 5'd13, ST_JPR    = 5'd14, ST_JAL   = 5'd15,
    ST_JRL    = 5'd16, ST_WWD    = 5'd17, ST_HALT   = 5'd18
  } stateT;

  stateT                stateReg, stateNext;
  logic [WAIT_W-1:0]    waitCnt;
  logic [WORD_SIZE-1:0] numInst;
  logic                 busError;
  logic [3:0]           opcode;
  logic [5:0]           func;
  logic                 memState, timeout, retire, decodeIllegal;
  logic                 unusedInst;

  assign opcode     = bus.inst[WORD_SIZE-1 -: 4];
  assign func       = bus.inst[5:0];
  assign unusedInst = ^bus.inst;

  // Timeout fires on the WAIT_LIMIT-th consecutive not-ready cycle.
  assign memState = stateReg inside {ST_FETCH, ST_MEM_RD, ST_MEM_WR};
  assign timeout  = memState && !bus.mem_ready && (waitCnt == WAIT_W'(WAIT_LIMIT - 1));

  always_comb begin
    stateNext     = stateReg;
    decodeIllegal = 1'b0;
    case (stateReg)
      ST_FETCH:  if (bus.mem_ready) stateNext = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_ALU: begin
            case (func)
              FN_WWD: stateNext = ST_WWD;
              FN_JPR: stateNext = ST_JPR;
              FN_JRL: stateNext = ST_JRL;
              FN_HLT: stateNext = ST_HALT;
              FN_ADD, FN_SUB, FN_AND, FN_ORR,
              FN_NOT, FN_TCP, FN_SHL, FN_SHR: stateNext = ST_R_EX;
              default: begin
                decodeIllegal = 1'b1;
                stateNext     = ST_FETCH;
              end
            endcase
          end
          OP_ADI:                         stateNext = ST_ADI;
          OP_ORI:                         stateNext = ST_ORI;
          OP_LHI:                         stateNext = ST_LHI;
          OP_LWD, OP_SWD:                 stateNext = ST_ADDR;
          OP_BEQ, OP_BNE, OP_BGZ, OP_BLZ: stateNext = ST_BRANCH;
          OP_JMP:                         stateNext = ST_JMP;
          OP_JAL:                         stateNext = ST_JAL;
          default: begin
            decodeIllegal = 1'b1;
            stateNext     = ST_FETCH;
          end
        endcase
      end
      ST_R_EX:                    stateNext = ST_R_WB;
      ST_ADI, ST_ORI, ST_LHI:     stateNext = ST_WB_RT;
      ST_ADDR: begin
        if (opcode == OP_LWD)      stateNext = ST_MEM_RD;
        else if (opcode == OP_SWD) stateNext = ST_MEM_WR;
        else                       stateNext = ST_FETCH;
      end
      ST_MEM_RD: if (bus.mem_ready) stateNext = ST_LD_WB;
      ST_MEM_WR: if (bus.mem_ready) stateNext = ST_FETCH;
      ST_HALT:                    stateNext = ST_HALT;
      default:                    stateNext = ST_FETCH;
    endcase
    if (timeout) stateNext = ST_HALT;
  end

  // A timeout into HALT is an abandoned instruction, not a retirement.
  assign retire = ((stateNext == ST_FETCH) && (stateReg != ST_FETCH)) ||
                  ((stateNext == ST_HALT) && (stateReg != ST_HALT) && !timeout);

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= ST_FETCH;
      waitCnt  <= '0;
      numInst  <= '0;
      busError <= 1'b0;
    end else begin
      stateReg <= stateNext;
      if (stateNext != stateReg)
        waitCnt <= '0;
      else if (memState && !bus.mem_ready)
        waitCnt <= waitCnt + WAIT_W'(1);
      if (retire)  numInst  <= numInst + WORD_SIZE'(1);
      if (timeout) busError <= 1'b1;
    end
  end

  always_comb begin
    bus.alu_src_a         = 1'b0;
    bus.i_or_d            = 1'b0;
    bus.ir_write          = 1'b0;
    bus.pc_write          = 1'b0;
    bus.pc_write_cond     = 1'b0;
    bus.alu_src_b         = 3'd0;
    bus.pc_source         = 2'd0;
    bus.reg_dest          = 2'd0;
    bus.reg_write_src     = 2'd0;
    bus.branch_property   = 2'd0;
    bus.alu_op            = 2'd0;
    bus.reg_write         = 1'b0;
    bus.mem_read          = 1'b0;
    bus.mem_write         = 1'b0;
    bus.output_port_write = 1'b0;
    bus.is_lhi            = 1'b0;
    bus.illegal_inst      = 1'b0;
    case (stateReg)
      ST_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 3'd1;
        bus.alu_op    = 2'd1;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      ST_DECODE: begin
        bus.alu_src_b    = 3'd3;
        bus.alu_op       = 2'd1;
        bus.illegal_inst = decodeIllegal;
      end
      ST_R_EX:   bus.alu_src_a = 1'b1;
      ST_R_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dest  = 2'd1;
      end
      ST_ADI, ST_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 3'd2;
        bus.alu_op    = 2'd1;
      end
      ST_ORI: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 3'd4;
        bus.alu_op    = 2'd2;
      end
      ST_LHI:    bus.is_lhi = 1'b1;
      ST_WB_RT: begin
        bus.reg_write = 1'b1;
        bus.is_lhi    = (opcode == OP_LHI);
      end
      ST_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      ST_LD_WB: begin
        bus.reg_write     = 1'b1;
        bus.reg_write_src = 2'd1;
      end
      ST_MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
      end
      ST_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'd1;
        bus.alu_op        = 2'd3;
        case (opcode)
          OP_BNE: bus.branch_property = 2'd1;
          OP_BGZ: begin
            bus.branch_property = 2'd2;
            bus.alu_src_b       = 3'd5;
          end
          OP_BLZ: begin
            bus.branch_property = 2'd3;
            bus.alu_src_b       = 3'd5;
          end
          default: bus.branch_property = 2'd0;
        endcase
      end
      ST_JMP, ST_JPR: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = (stateReg == ST_JPR) ? 2'd3 : 2'd2;
      end
      ST_JAL, ST_JRL: begin
        bus.pc_write      = 1'b1;
        bus.pc_source     = (stateReg == ST_JRL) ? 2'd3 : 2'd2;
        bus.reg_write     = 1'b1;
        bus.reg_dest      = 2'd2;
        bus.reg_write_src = 2'd2;
      end
      ST_WWD:    bus.output_port_write = 1'b1;
      default: ;
    endcase
  end

  assign bus.state     = stateReg;
  assign bus.halted    = (stateReg == ST_HALT);
  assign bus.bus_error = busError;
  assign bus.num_inst  = numInst;

endmodule

// File: tb/tb_multicycle_useq.sv
// Directed bench for multicycle_useq: per-cycle expected state/controls are queued
// as each cycle's inputs are driven and popped when the outputs are sampled.
module tb_multicycle_useq;
  localparam logic [4:0] S_FETCH = 5'd0,  S_DECODE = 5'd1,  S_R_EX = 5'd2,   S_R_WB = 5'd3;
  localparam logic [4:0] S_ADI = 5'd4,    S_ORI = 5'd5,     S_LHI = 5'd6,    S_WB_RT = 5'd7;
  localparam logic [4:0] S_ADDR = 5'd8,   S_MEM_RD = 5'd9,  S_LD_WB = 5'd10, S_MEM_WR = 5'd11;
  localparam logic [4:0] S_BRANCH = 5'd12, S_JMP = 5'd13,   S_JPR = 5'd14,   S_JAL = 5'd15;
  localparam logic [4:0] S_JRL = 5'd16,   S_WWD = 5'd17,    S_HALT = 5'd18;

  localparam logic [15:0] I_ADI = 16'h4123, I_ORI = 16'h5A5A, I_LHI = 16'h6077;
  localparam logic [15:0] I_LWD = 16'h7204, I_SWD = 16'h8308;
  localparam logic [15:0] I_BNE = 16'h0410, I_BEQ = 16'h1520, I_BGZ = 16'h2630, I_BLZ = 16'h3740;
  localparam logic [15:0] I_JMP = 16'h9055, I_JAL = 16'hA066;
  localparam logic [15:0] I_ADD = 16'hF180, I_SHR = 16'hF187, I_JPR = 16'hF019, I_JRL = 16'hF01A;
  localparam logic [15:0] I_WWD = 16'hF01C, I_HLT = 16'hF01D, I_BADOP = 16'hE000, I_BADFN = 16'hF011;

  typedef struct packed {
    logic       aluSrcA, iOrD, irWrite, pcWrite, pcWriteCond;
    logic [2:0] aluSrcB;
    logic [1:0] pcSource, regDest, regWriteSrc, branchProperty, aluOp;
    logic       regWrite, memRead, memWrite, outWrite, isLhi, illegal;
  } ctlT;

  typedef struct packed {
    logic [4:0]  st;
    ctlT         ctl;
    logic [15:0] n;
    logic        be;
    logic        hl;
  } expT;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  logic  reset10 = 1'b1;
  int    checks = 0;
  int    errors = 0;
  int    expN = 0;
  logic  expBe = 1'b0;
  string stepName = "init";
  expT   expQ[$];

  always #5 clk = ~clk;

  multicycle_useq_if #(.WORD_SIZE(16)) bus16 ();
  multicycle_useq_if #(.WORD_SIZE(10)) bus10 ();

  multicycle_useq #(.WORD_SIZE(16), .WAIT_LIMIT(15), .WAIT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus16)
  );
  multicycle_useq #(.WORD_SIZE(10), .WAIT_LIMIT(15), .WAIT_W(8)) dut10 (
    .clk(clk), .reset(reset10), .bus(bus10)
  );

  function automatic logic isIllegal(input logic [15:0] ins);
    logic [3:0] op;
    logic [5:0] fn;
    op = ins[15:12];
    fn = ins[5:0];
    if (op == 4'hF) return !((fn <= 6'd7) || fn == 6'd25 || fn == 6'd26 || fn == 6'd28 || fn == 6'd29);
    return (op > 4'd10);
  endfunction

  function automatic ctlT ctlFor(input logic [4:0] st, input logic [15:0] ins, input logic rdy);
    ctlT c;
    c = '0;
    case (st)
      S_FETCH:  begin c.memRead = 1; c.aluSrcB = 3'd1; c.aluOp = 2'd1; c.irWrite = rdy; c.pcWrite = rdy; end
      S_DECODE: begin c.aluSrcB = 3'd3; c.aluOp = 2'd1; c.illegal = isIllegal(ins); end
      S_R_EX:   c.aluSrcA = 1;
      S_R_WB:   begin c.regWrite = 1; c.regDest = 2'd1; end
      S_ADI:    begin c.aluSrcA = 1; c.aluSrcB = 3'd2; c.aluOp = 2'd1; end
      S_ORI:    begin c.aluSrcA = 1; c.aluSrcB = 3'd4; c.aluOp = 2'd2; end
      S_LHI:    c.isLhi = 1;
      S_WB_RT:  begin c.regWrite = 1; c.isLhi = (ins[15:12] == 4'd6); end
      S_ADDR:   begin c.aluSrcA = 1; c.aluSrcB = 3'd2; c.aluOp = 2'd1; end
      S_MEM_RD: begin c.memRead = 1; c.iOrD = 1; end
      S_LD_WB:  begin c.regWrite = 1; c.regWriteSrc = 2'd1; end
      S_MEM_WR: begin c.memWrite = 1; c.iOrD = 1; end
      S_BRANCH: begin
        c.aluSrcA = 1; c.pcWriteCond = 1; c.pcSource = 2'd1; c.aluOp = 2'd3;
        case (ins[15:12])
          4'd0: c.branchProperty = 2'd1;
          4'd2: begin c.branchProperty = 2'd2; c.aluSrcB = 3'd5; end
          4'd3: begin c.branchProperty = 2'd3; c.aluSrcB = 3'd5; end
          default: ;
        endcase
      end
      S_JMP:    begin c.pcWrite = 1; c.pcSource = 2'd2; end
      S_JPR:    begin c.pcWrite = 1; c.pcSource = 2'd3; end
      S_JAL:    begin c.pcWrite = 1; c.pcSource = 2'd2; c.regWrite = 1; c.regDest = 2'd2; c.regWriteSrc = 2'd2; end
      S_JRL:    begin c.pcWrite = 1; c.pcSource = 2'd3; c.regWrite = 1; c.regDest = 2'd2; c.regWriteSrc = 2'd2; end
      S_WWD:    c.outWrite = 1;
      default: ;
    endcase
    return c;
  endfunction

  function automatic ctlT getCtl();
    ctlT c;
    c.aluSrcA = bus16.alu_src_a;          c.iOrD = bus16.i_or_d;
    c.irWrite = bus16.ir_write;           c.pcWrite = bus16.pc_write;
    c.pcWriteCond = bus16.pc_write_cond;  c.aluSrcB = bus16.alu_src_b;
    c.pcSource = bus16.pc_source;         c.regDest = bus16.reg_dest;
    c.regWriteSrc = bus16.reg_write_src;  c.branchProperty = bus16.branch_property;
    c.aluOp = bus16.alu_op;               c.regWrite = bus16.reg_write;
    c.memRead = bus16.mem_read;           c.memWrite = bus16.mem_write;
    c.outWrite = bus16.output_port_write; c.isLhi = bus16.is_lhi;
    c.illegal = bus16.illegal_inst;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s [%s] observed=%0h expected=%0h", tag, stepName, obs, exp);
    end
  endtask

  task automatic tick(input logic [4:0] st, input logic rdy, input logic [15:0] ins);
    expT e;
    @(negedge clk);
    reset = 1'b0;
    bus16.mem_ready = rdy;
    bus16.inst = ins;
    e.st  = st;
    e.ctl = ctlFor(st, ins, rdy);
    e.n   = 16'(expN);
    e.be  = expBe;
    e.hl  = (st == S_HALT);
    expQ.push_back(e);
    #1;
    e = expQ.pop_front();
    chk("state", 32'(bus16.state), 32'(e.st));
    chk("controls", 32'(getCtl()), 32'(e.ctl));
    chk("num_inst", 32'(bus16.num_inst), 32'(e.n));
    chk("bus_error", 32'(bus16.bus_error), 32'(e.be));
    chk("halted", 32'(bus16.halted), 32'(e.hl));
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    bus16.mem_ready = 1'b0;
    @(negedge clk);
    #1;
    expN  = 0;
    expBe = 1'b0;
    chk("rst_state", 32'(bus16.state), 32'(S_FETCH));
    chk("rst_num_inst", 32'(bus16.num_inst), 32'd0);
    chk("rst_bus_error", 32'(bus16.bus_error), 32'd0);
    chk("rst_halted", 32'(bus16.halted), 32'd0);
    chk("rst_illegal", 32'(bus16.illegal_inst), 32'd0);
    chk("rst_mem_write", 32'(bus16.mem_write), 32'd0);
  endtask

  // fw / mw: not-ready cycles in FETCH / in the data memory state.
  task automatic runInst(input logic [15:0] ins, input int fw, input int mw);
    for (int i = 0; i < fw; i++) tick(S_FETCH, 1'b0, ins);
    tick(S_FETCH, 1'b1, ins);
    tick(S_DECODE, 1'b1, ins);
    if (!isIllegal(ins)) begin
      case (ins[15:12])
        4'hF: begin
          case (ins[5:0])
            6'd28:   tick(S_WWD, 1'b1, ins);
            6'd25:   tick(S_JPR, 1'b1, ins);
            6'd26:   tick(S_JRL, 1'b1, ins);
            6'd29:   ;
            default: begin tick(S_R_EX, 1'b1, ins); tick(S_R_WB, 1'b1, ins); end
          endcase
        end
        4'd4: begin tick(S_ADI, 1'b1, ins); tick(S_WB_RT, 1'b1, ins); end
        4'd5: begin tick(S_ORI, 1'b1, ins); tick(S_WB_RT, 1'b1, ins); end
        4'd6: begin tick(S_LHI, 1'b1, ins); tick(S_WB_RT, 1'b1, ins); end
        4'd7: begin
          tick(S_ADDR, 1'b1, ins);
          for (int i = 0; i < mw; i++) tick(S_MEM_RD, 1'b0, ins);
          tick(S_MEM_RD, 1'b1, ins);
          tick(S_LD_WB, 1'b1, ins);
        end
        4'd8: begin
          tick(S_ADDR, 1'b1, ins);
          for (int i = 0; i < mw; i++) tick(S_MEM_WR, 1'b0, ins);
          tick(S_MEM_WR, 1'b1, ins);
        end
        4'd9:  tick(S_JMP, 1'b1, ins);
        4'd10: tick(S_JAL, 1'b1, ins);
        default: tick(S_BRANCH, 1'b1, ins);
      endcase
    end
    expN = (expN + 1) % 65536;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus16.inst = 16'h0;
    bus16.mem_ready = 1'b0;
    bus10.inst = 10'h380;
    bus10.mem_ready = 1'b1;

    stepName = "reset";      doReset();
    stepName = "adi_add_wwd";
    runInst(I_ADI, 0, 0); runInst(I_ADD, 0, 0); runInst(I_WWD, 0, 0);
    tick(S_FETCH, 1'b0, I_ADD);
    chk("num_after_three", 32'(bus16.num_inst), 32'd3);

    stepName = "lwd_3_waits"; runInst(I_LWD, 0, 3);
    stepName = "illegal_op";  runInst(I_BADOP, 0, 0);
    stepName = "illegal_fn";  runInst(I_BADFN, 0, 0);
    stepName = "branches";
    runInst(I_BGZ, 0, 0); runInst(I_BEQ, 0, 0); runInst(I_BNE, 0, 0); runInst(I_BLZ, 0, 0);
    stepName = "imm_mem";
    runInst(I_ORI, 2, 0); runInst(I_LHI, 0, 0); runInst(I_SWD, 1, 2); runInst(I_SHR, 0, 0);
    stepName = "jumps";
    runInst(I_JMP, 0, 0); runInst(I_JAL, 0, 0); runInst(I_JPR, 0, 0); runInst(I_JRL, 0, 0);
    stepName = "wait_limit_edge";
    runInst(I_ADI, 14, 0); runInst(I_LWD, 0, 14); runInst(I_SWD, 0, 14);

    stepName = "halt";
    runInst(I_HLT, 0, 0);
    for (int i = 0; i < 3; i++) tick(S_HALT, 1'b1, I_ADD);
    stepName = "halt_reset"; doReset();

    stepName = "fetch_timeout";
    runInst(I_ADI, 0, 0);
    for (int i = 0; i < 15; i++) tick(S_FETCH, 1'b0, I_ADD);
    expBe = 1'b1;
    for (int i = 0; i < 3; i++) tick(S_HALT, 1'b1, I_ADD);
    doReset();

    stepName = "mem_rd_timeout";
    runInst(I_JMP, 0, 0);
    tick(S_FETCH, 1'b1, I_LWD); tick(S_DECODE, 1'b1, I_LWD); tick(S_ADDR, 1'b1, I_LWD);
    for (int i = 0; i < 15; i++) tick(S_MEM_RD, 1'b0, I_LWD);
    expBe = 1'b1;
    tick(S_HALT, 1'b1, I_LWD);
    doReset();

    stepName = "reset_in_mem_wr";
    runInst(I_ADD, 0, 0);
    tick(S_FETCH, 1'b1, I_SWD); tick(S_DECODE, 1'b1, I_SWD); tick(S_ADDR, 1'b1, I_SWD);
    tick(S_MEM_WR, 1'b0, I_SWD); tick(S_MEM_WR, 1'b0, I_SWD);
    doReset();
    runInst(I_JMP, 0, 0);
    tick(S_FETCH, 1'b0, I_ADD);

    stepName = "wrap_10bit";
    @(negedge clk);
    reset10 = 1'b0;
    repeat (2046) @(negedge clk);
    #1;
    chk("wrap_pre_num", 32'(bus10.num_inst), 32'h3FF);
    chk("wrap_pre_state", 32'(bus10.state), 32'(S_FETCH));
    @(negedge clk);
    #1;
    chk("wrap_illegal_pulse", 32'(bus10.illegal_inst), 32'd1);
    @(negedge clk);
    #1;
    chk("wrap_num", 32'(bus10.num_inst), 32'd0);
    chk("wrap_state", 32'(bus10.state), 32'(S_FETCH));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
